// File: rtl/ram_arbiter.sv
// Shares the single system RAM port between the 6502 core, the VGA reader and the UART loader.
// The CPU is only halted on an instruction boundary, and its held address is replayed before RDY returns.
module ram_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 11,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned SYNC_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic                  cpu_we,
    input  logic                  cpu_sync,
    output logic                  cpu_rdy,
    input  logic                  vga_req,
    input  logic [ADDR_WIDTH-1:0] vga_addr,
    output logic                  vga_grant,
    output logic                  vga_rdata_valid,
    input  logic                  uart_req,
    input  logic [ADDR_WIDTH-1:0] uart_addr,
    input  logic [DATA_WIDTH-1:0] uart_wdata,
    input  logic                  uart_we,
    output logic                  uart_grant,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_we
);

    localparam int unsigned TIMER_WIDTH = 5;
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(SYNC_TIMEOUT - 1);

    typedef enum logic [2:0] {
        CPU_RUN,
        DRAIN,
        VGA_OWN,
        UART_OWN,
        RESTORE
    } state_t;

    state_t                  state;
    logic [TIMER_WIDTH-1:0]  timer;
    logic [ADDR_WIDTH-1:0]   held_addr;
    logic                    rdy_q;
    logic                    any_req;
    logic                    halt;
    logic                    unused_addr_bits;

    assign unused_addr_bits = &{1'b0, cpu_addr[15:ADDR_WIDTH]};

    assign any_req = vga_req | uart_req;

    // The DRAIN timeout covers a CPU held in reset that never presents SYNC.
    assign halt = any_req &&
                  (((state == CPU_RUN) && cpu_sync) ||
                   ((state == DRAIN) && (cpu_sync || (timer == TIMER_LAST))));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= RESTORE;
            cpu_rdy         <= 1'b0;
            vga_grant       <= 1'b0;
            uart_grant      <= 1'b0;
            vga_rdata_valid <= 1'b0;
            held_addr       <= '0;
            timer           <= '0;
            rdy_q           <= 1'b0;
        end else begin
            rdy_q           <= cpu_rdy;
            vga_rdata_valid <= vga_grant & vga_req;

            // The core holds AB while paused; latch it once for the replay cycle.
            if (!cpu_rdy && rdy_q) begin
                held_addr <= cpu_addr[ADDR_WIDTH-1:0];
            end

            if (halt) begin
                cpu_rdy <= 1'b0;
                timer   <= '0;
                if (uart_req) begin
                    state      <= UART_OWN;
                    uart_grant <= 1'b1;
                end else begin
                    state     <= VGA_OWN;
                    vga_grant <= 1'b1;
                end
            end else begin
                case (state)
                    CPU_RUN: begin
                        timer <= '0;
                        if (any_req) begin
                            state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (!any_req) begin
                            state <= CPU_RUN;
                            timer <= '0;
                        end else begin
                            timer <= timer + TIMER_WIDTH'(1);
                        end
                    end
                    VGA_OWN: begin
                        if (!vga_req) begin
                            vga_grant <= 1'b0;
                            if (uart_req) begin
                                state      <= UART_OWN;
                                uart_grant <= 1'b1;
                            end else begin
                                state <= RESTORE;
                            end
                        end
                    end
                    UART_OWN: begin
                        if (!uart_req) begin
                            uart_grant <= 1'b0;
                            if (vga_req) begin
                                state     <= VGA_OWN;
                                vga_grant <= 1'b1;
                            end else begin
                                state <= RESTORE;
                            end
                        end
                    end
                    RESTORE: begin
                        state   <= CPU_RUN;
                        cpu_rdy <= 1'b1;
                    end
                    default: begin
                        state <= RESTORE;
                    end
                endcase
            end
        end
    end

    // RAM port steering by current owner.
    always_comb begin
        ram_raddr = cpu_addr[ADDR_WIDTH-1:0];
        ram_waddr = cpu_addr[ADDR_WIDTH-1:0];
        ram_wdata = cpu_wdata;
        case (state)
            VGA_OWN: begin
                ram_raddr = vga_addr;
                ram_waddr = vga_addr;
            end
            UART_OWN: begin
                ram_raddr = uart_addr;
                ram_waddr = uart_addr;
                ram_wdata = uart_wdata;
            end
            RESTORE: begin
                ram_raddr = held_addr;
                ram_waddr = held_addr;
            end
            default: ;
        endcase
    end

    assign ram_we = (cpu_we & cpu_rdy) | (uart_we & uart_grant);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: reset, sync-gated halt, priority, replay cycle and sync timeout.
module tb_ram_arbiter;

    localparam int unsigned ADDR_WIDTH   = 11;
    localparam int unsigned DATA_WIDTH   = 8;
    localparam int unsigned SYNC_TIMEOUT = 16;

    logic                  clk;
    logic                  reset;
    logic [15:0]           cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cpu_we;
    logic                  cpu_sync;
    logic                  cpu_rdy;
    logic                  vga_req;
    logic [ADDR_WIDTH-1:0] vga_addr;
    logic                  vga_grant;
    logic                  vga_rdata_valid;
    logic                  uart_req;
    logic [ADDR_WIDTH-1:0] uart_addr;
    logic [DATA_WIDTH-1:0] uart_wdata;
    logic                  uart_we;
    logic                  uart_grant;
    logic [ADDR_WIDTH-1:0] ram_raddr;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic                  ram_we;

    int tests_run = 0;
    int tests_failed = 0;

    ram_arbiter #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .SYNC_TIMEOUT(SYNC_TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_we         (cpu_we),
        .cpu_sync       (cpu_sync),
        .cpu_rdy        (cpu_rdy),
        .vga_req        (vga_req),
        .vga_addr       (vga_addr),
        .vga_grant      (vga_grant),
        .vga_rdata_valid(vga_rdata_valid),
        .uart_req       (uart_req),
        .uart_addr      (uart_addr),
        .uart_wdata     (uart_wdata),
        .uart_we        (uart_we),
        .uart_grant     (uart_grant),
        .ram_raddr      (ram_raddr),
        .ram_waddr      (ram_waddr),
        .ram_wdata      (ram_wdata),
        .ram_we         (ram_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are then driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset = 1'b1;
        cpu_addr = 16'h0042; cpu_wdata = '0; cpu_we = 1'b0; cpu_sync = 1'b0;
        vga_req = 1'b0; vga_addr = '0;
        uart_req = 1'b0; uart_addr = '0; uart_wdata = '0; uart_we = 1'b0;
        step(); step();

        // 1: reset values, then one RESTORE cycle before the CPU runs
        check("rst_rdy", 32'(cpu_rdy), 32'd0);
        check("rst_vga_grant", 32'(vga_grant), 32'd0);
        check("rst_uart_grant", 32'(uart_grant), 32'd0);
        check("rst_valid", 32'(vga_rdata_valid), 32'd0);
        check("rst_raddr_held", 32'(ram_raddr), 32'h000);
        reset = 1'b0;
        #1;
        check("restore_rdy", 32'(cpu_rdy), 32'd0);
        step();
        check("run_rdy", 32'(cpu_rdy), 32'd1);
        check("run_raddr", 32'(ram_raddr), 32'h042);
        cpu_we = 1'b1; cpu_wdata = 8'h3C;
        #1;
        check("cpu_we_pass", 32'(ram_we), 32'd1);
        check("cpu_waddr", 32'(ram_waddr), 32'h042);
        check("cpu_wdata", 32'(ram_wdata), 32'h3C);
        cpu_we = 1'b0;

        // Request dropped while draining returns to CPU_RUN without a grant
        vga_req = 1'b1;
        step();
        vga_req = 1'b0;
        step();
        check("drain_drop_rdy", 32'(cpu_rdy), 32'd1);
        check("drain_drop_grant", 32'(vga_grant), 32'd0);

        // 2: VGA request waits for SYNC
        vga_req = 1'b1; vga_addr = 11'h155;
        step(); step(); step();
        check("drain_rdy", 32'(cpu_rdy), 32'd1);
        check("drain_no_grant", 32'(vga_grant), 32'd0);
        cpu_sync = 1'b1; cpu_addr = 16'h0123;
        #1;
        check("sync_cycle_rdy", 32'(cpu_rdy), 32'd1);
        step();
        cpu_sync = 1'b0;
        check("vga_halt_rdy", 32'(cpu_rdy), 32'd0);
        check("vga_grant", 32'(vga_grant), 32'd1);
        check("vga_raddr", 32'(ram_raddr), 32'h155);
        check("vga_valid_early", 32'(vga_rdata_valid), 32'd0);
        step();
        check("vga_valid", 32'(vga_rdata_valid), 32'd1);
        check("vga_grant_hold", 32'(vga_grant), 32'd1);
        // 6a: CPU writes are blocked while paused
        cpu_we = 1'b1;
        #1;
        check("cpu_we_blocked", 32'(ram_we), 32'd0);
        cpu_we = 1'b0;

        // 3: replay held address for one cycle
        vga_req = 1'b0;
        step();
        cpu_addr = 16'h7456;
        check("restore_grant", 32'(vga_grant), 32'd0);
        check("restore_rdy2", 32'(cpu_rdy), 32'd0);
        check("restore_raddr", 32'(ram_raddr), 32'h123);
        check("restore_valid", 32'(vga_rdata_valid), 32'd0);
        step();
        check("resume_rdy", 32'(cpu_rdy), 32'd1);
        check("resume_raddr", 32'(ram_raddr), 32'h456);

        // 4: UART wins over VGA, then VGA follows with no RESTORE
        uart_req = 1'b1; vga_req = 1'b1; cpu_sync = 1'b1;
        uart_addr = 11'h200; uart_wdata = 8'hA5; uart_we = 1'b1; vga_addr = 11'h0AA;
        step();
        cpu_sync = 1'b0;
        check("uart_grant", 32'(uart_grant), 32'd1);
        check("uart_vga_blocked", 32'(vga_grant), 32'd0);
        check("uart_rdy", 32'(cpu_rdy), 32'd0);
        check("uart_we", 32'(ram_we), 32'd1);
        check("uart_waddr", 32'(ram_waddr), 32'h200);
        check("uart_wdata", 32'(ram_wdata), 32'hA5);
        uart_req = 1'b0; uart_we = 1'b0;
        step();
        check("handoff_vga_grant", 32'(vga_grant), 32'd1);
        check("handoff_uart_grant", 32'(uart_grant), 32'd0);
        check("handoff_rdy", 32'(cpu_rdy), 32'd0);
        check("handoff_raddr", 32'(ram_raddr), 32'h0AA);
        check("handoff_we", 32'(ram_we), 32'd0);
        step();
        check("handoff_valid", 32'(vga_rdata_valid), 32'd1);
        vga_req = 1'b0;
        step();
        check("restore2_rdy", 32'(cpu_rdy), 32'd0);
        check("restore2_raddr", 32'(ram_raddr), 32'h456);
        step();
        check("resume2_rdy", 32'(cpu_rdy), 32'd1);

        // 5: SYNC never arrives, halt is forced by the timeout
        uart_req = 1'b1; uart_addr = 11'h300;
        n = 0;
        while (!uart_grant && n < 40) begin
            step();
            n++;
        end
        check("timeout_latency", 32'(n), 32'(SYNC_TIMEOUT + 1));
        check("timeout_rdy", 32'(cpu_rdy), 32'd0);

        // 6b: asynchronous reset during UART ownership
        uart_we = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("async_uart_grant", 32'(uart_grant), 32'd0);
        check("async_rdy", 32'(cpu_rdy), 32'd0);
        check("async_we", 32'(ram_we), 32'd0);
        uart_req = 1'b0; uart_we = 1'b0;
        step();
        reset = 1'b0;
        #1;
        check("post_rst_rdy", 32'(cpu_rdy), 32'd0);
        step();
        check("post_rst_run", 32'(cpu_rdy), 32'd1);
        check("post_rst_grant", 32'(uart_grant), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
